// File: rtl/pingpong_buf_ctrl.sv
// Ping-pong tile buffer controller: the producer fills one RAM bank while the consumer drains
// the other, with a 2-entry fall-through FIFO absorbing the one-cycle bank read latency.
module pingpong_buf_ctrl #(
    parameter int              NUM_RAMS = 8,
    parameter int              W        = 128,
    parameter longint unsigned D        = 128
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_vld,
    output logic                   in_rdy,
    input  logic [NUM_RAMS*W-1:0]  in_dat,
    output logic                   out_vld,
    input  logic                   out_rdy,
    output logic [NUM_RAMS*W-1:0]  out_dat,
    output logic                   we_A,
    output logic                   we_B,
    output logic [NUM_RAMS*32-1:0] write_addr_A,
    output logic [NUM_RAMS*32-1:0] write_addr_B,
    output logic [NUM_RAMS*W-1:0]  din_A,
    output logic [NUM_RAMS*W-1:0]  din_B,
    output logic                   re_A,
    output logic                   re_B,
    output logic [NUM_RAMS*32-1:0] read_addr_A,
    output logic [NUM_RAMS*32-1:0] read_addr_B,
    input  logic                   dout_vld_A,
    input  logic                   dout_vld_B,
    input  logic [NUM_RAMS*W-1:0]  dout_A,
    input  logic [NUM_RAMS*W-1:0]  dout_B,
    output logic                   wr_done,
    output logic                   rd_done,
    output logic [1:0]             bank_full
);
    localparam int              DW   = NUM_RAMS * W;
    localparam int              CW   = $clog2(D);
    localparam logic [CW-1:0]   LAST = CW'(D - 64'd1);

    logic [1:0]    full_r;
    logic          wr_bank_r;
    logic          rd_bank_r;
    logic [CW-1:0] wr_cnt_r;
    logic [CW-1:0] rd_cnt_r;
    logic [DW-1:0] fifo_mem_r [2];
    logic          fifo_wp_r;
    logic          fifo_rp_r;
    logic [1:0]    fifo_cnt_r;
    logic [1:0]    infl_r;
    logic          wr_done_r;
    logic          rd_done_r;

    logic          wr_acc_s;
    logic          rd_iss_s;
    logic          wr_last_s;
    logic          rd_last_s;
    logic          ret_s;
    logic          push_s;
    logic          pop_s;
    logic [2:0]    occ_sum_s;
    logic [DW-1:0] push_dat_s;
    logic [1:0]    full_nxt_s;
    logic [1:0]    fifo_cnt_nxt_s;
    logic [1:0]    infl_nxt_s;

    assign in_rdy     = !rst && !full_r[wr_bank_r];
    assign wr_acc_s   = in_vld && in_rdy;
    assign wr_last_s  = wr_acc_s && (wr_cnt_r == LAST);
    // Reads are throttled so that every issued row is guaranteed a FIFO slot on return.
    assign occ_sum_s  = {1'b0, fifo_cnt_r} + {1'b0, infl_r};
    assign rd_iss_s   = !rst && full_r[rd_bank_r] && (occ_sum_s < 3'd2);
    assign rd_last_s  = rd_iss_s && (rd_cnt_r == LAST);
    assign ret_s      = !rst && (dout_vld_A || dout_vld_B);
    assign push_s     = ret_s && (fifo_cnt_r != 2'd2);
    assign out_vld    = !rst && (fifo_cnt_r != 2'd0);
    assign pop_s      = out_vld && out_rdy;
    assign push_dat_s = dout_vld_A ? dout_A : dout_B;

    assign we_A      = wr_acc_s && (wr_bank_r == 1'b0);
    assign we_B      = wr_acc_s && (wr_bank_r == 1'b1);
    assign re_A      = rd_iss_s && (rd_bank_r == 1'b0);
    assign re_B      = rd_iss_s && (rd_bank_r == 1'b1);
    assign wr_done   = !rst && wr_done_r;
    assign rd_done   = !rst && rd_done_r;
    assign bank_full = rst ? 2'b00 : full_r;

    // A bank can never be both the write target and the read source, so set and clear never collide.
    assign full_nxt_s[0] = (wr_last_s && !wr_bank_r) ? 1'b1 :
                           (rd_last_s && !rd_bank_r) ? 1'b0 : full_r[0];
    assign full_nxt_s[1] = (wr_last_s &&  wr_bank_r) ? 1'b1 :
                           (rd_last_s &&  rd_bank_r) ? 1'b0 : full_r[1];

    // Address, write-data and read-data buses, forced to zero while in reset.
    always_comb begin
        write_addr_A = '0;
        write_addr_B = '0;
        read_addr_A  = '0;
        read_addr_B  = '0;
        din_A        = '0;
        din_B        = '0;
        out_dat      = '0;
        if (rst) begin
            out_dat = '0;
        end else begin
            write_addr_A = {NUM_RAMS{32'(wr_cnt_r)}};
            write_addr_B = {NUM_RAMS{32'(wr_cnt_r)}};
            read_addr_A  = {NUM_RAMS{32'(rd_cnt_r)}};
            read_addr_B  = {NUM_RAMS{32'(rd_cnt_r)}};
            din_A        = in_dat;
            din_B        = in_dat;
            if (out_vld) begin
                out_dat = fifo_mem_r[fifo_rp_r];
            end else begin
                out_dat = '0;
            end
        end
    end

    // Occupancy bookkeeping for the output FIFO and the reads still in flight.
    always_comb begin
        fifo_cnt_nxt_s = fifo_cnt_r;
        infl_nxt_s     = infl_r;
        case ({push_s, pop_s})
            2'b10:   fifo_cnt_nxt_s = fifo_cnt_r + 2'd1;
            2'b01:   fifo_cnt_nxt_s = fifo_cnt_r - 2'd1;
            default: fifo_cnt_nxt_s = fifo_cnt_r;
        endcase
        case ({rd_iss_s, ret_s && (infl_r != 2'd0)})
            2'b10:   infl_nxt_s = infl_r + 2'd1;
            2'b01:   infl_nxt_s = infl_r - 2'd1;
            default: infl_nxt_s = infl_r;
        endcase
    end

    // Pointer, bank-state, FIFO and done-pulse registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            full_r        <= 2'b00;
            wr_bank_r     <= 1'b0;
            rd_bank_r     <= 1'b0;
            wr_cnt_r      <= '0;
            rd_cnt_r      <= '0;
            fifo_mem_r[0] <= '0;
            fifo_mem_r[1] <= '0;
            fifo_wp_r     <= 1'b0;
            fifo_rp_r     <= 1'b0;
            fifo_cnt_r    <= 2'd0;
            infl_r        <= 2'd0;
            wr_done_r     <= 1'b0;
            rd_done_r     <= 1'b0;
        end else begin
            full_r     <= full_nxt_s;
            fifo_cnt_r <= fifo_cnt_nxt_s;
            infl_r     <= infl_nxt_s;
            wr_done_r  <= wr_last_s;
            rd_done_r  <= rd_last_s;
            if (wr_last_s) begin
                wr_cnt_r  <= '0;
                wr_bank_r <= ~wr_bank_r;
            end else if (wr_acc_s) begin
                wr_cnt_r <= wr_cnt_r + CW'(1);
            end
            if (rd_last_s) begin
                rd_cnt_r  <= '0;
                rd_bank_r <= ~rd_bank_r;
            end else if (rd_iss_s) begin
                rd_cnt_r <= rd_cnt_r + CW'(1);
            end
            if (push_s) begin
                fifo_mem_r[fifo_wp_r] <= push_dat_s;
                fifo_wp_r             <= ~fifo_wp_r;
            end
            if (pop_s) begin
                fifo_rp_r <= ~fifo_rp_r;
            end
        end
    end
endmodule

// File: tb/tb_pingpong_buf_ctrl.sv
// Randomized bench for pingpong_buf_ctrl: per-lane RAM models plus a tile-level reference model
// (rows accepted/issued counted as plain integers, an in-order scoreboard of accepted rows).
module tb_pingpong_buf_ctrl;
    localparam int NR = 4;
    localparam int W  = 16;
    localparam int D  = 4;
    localparam int DW = NR * W;
    localparam int AW = NR * 32;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst = 1'b1;
    logic          in_vld = 1'b0;
    logic          out_rdy = 1'b0;
    logic [DW-1:0] in_dat = '0;
    logic          in_rdy, out_vld, we_A, we_B, re_A, re_B, wr_done, rd_done;
    logic [DW-1:0] out_dat, din_A, din_B;
    logic [AW-1:0] write_addr_A, write_addr_B, read_addr_A, read_addr_B;
    logic [1:0]    bank_full;
    logic          dout_vld_A = 1'b0;
    logic          dout_vld_B = 1'b0;
    logic [DW-1:0] dout_A = '0;
    logic [DW-1:0] dout_B = '0;

    pingpong_buf_ctrl #(.NUM_RAMS(NR), .W(W), .D(D)) dut (
        .clk(clk), .rst(rst), .in_vld(in_vld), .in_rdy(in_rdy), .in_dat(in_dat),
        .out_vld(out_vld), .out_rdy(out_rdy), .out_dat(out_dat),
        .we_A(we_A), .we_B(we_B), .write_addr_A(write_addr_A), .write_addr_B(write_addr_B),
        .din_A(din_A), .din_B(din_B), .re_A(re_A), .re_B(re_B),
        .read_addr_A(read_addr_A), .read_addr_B(read_addr_B),
        .dout_vld_A(dout_vld_A), .dout_vld_B(dout_vld_B), .dout_A(dout_A), .dout_B(dout_B),
        .wr_done(wr_done), .rd_done(rd_done), .bank_full(bank_full)
    );

    // One RAM per lane per bank, read data one cycle after re.
    logic [W-1:0] mem_a [NR][D];
    logic [W-1:0] mem_b [NR][D];
    always @(posedge clk) begin
        for (int l = 0; l < NR; l++) begin
            if (we_A) mem_a[l][write_addr_A[l*32 +: 2]] <= din_A[l*W +: W];
            if (we_B) mem_b[l][write_addr_B[l*32 +: 2]] <= din_B[l*W +: W];
            dout_A[l*W +: W] <= mem_a[l][read_addr_A[l*32 +: 2]];
            dout_B[l*W +: W] <= mem_b[l][read_addr_B[l*32 +: 2]];
        end
        dout_vld_A <= re_A;
        dout_vld_B <= re_B;
    end

    int n_tests = 0;
    int n_fail  = 0;
    int wr_total = 0, rd_total = 0, occ = 0, infl = 0, cyc = 0;
    int first_re = -1, first_ov = -1, wr_done_seen = 0, rd_done_seen = 0;
    bit exp_wr_done = 1'b0, exp_rd_done = 1'b0;
    logic [DW-1:0] sb [$];

    // Tiles k in [read tiles done, write tiles done) are FULL, tile k lives in bank k%2.
    function automatic logic [1:0] full_bits(input int wtot, input int rtot);
        logic [1:0] f = 2'b00;
        for (int k = rtot / D; k < wtot / D; k++) f[k % 2] = 1'b1;
        return f;
    endfunction

    // Cycle monitor: compares every handshake and bus against the tile-level model.
    always @(negedge clk) begin
        int wt, rt;
        bit acc, rd_ok, pop, ret;
        logic [1:0] exp_we, exp_re, exp_full;
        logic [31:0] a;
        #2;
        cyc++;
        if (rst) begin
            n_tests++;
            if ({in_rdy, out_vld, we_A, we_B, re_A, re_B, wr_done, rd_done, bank_full} !== 10'd0) begin
                n_fail++;
                $display("FAIL rst_outputs got %b required 0", {in_rdy, out_vld, we_A, we_B, re_A, re_B, wr_done, rd_done, bank_full});
            end
            wr_total = 0; rd_total = 0; occ = 0; infl = 0;
            exp_wr_done = 1'b0; exp_rd_done = 1'b0;
            sb.delete();
        end else begin
            wt = wr_total / D;
            rt = rd_total / D;
            exp_full = full_bits(wr_total, rd_total);
            n_tests++;
            if (bank_full !== exp_full) begin
                n_fail++; $display("FAIL bank_full got %b required %b", bank_full, exp_full);
            end
            n_tests++;
            if (in_rdy !== ((wt - rt) < 2)) begin
                n_fail++; $display("FAIL in_rdy got %b required %b", in_rdy, (wt - rt) < 2);
            end
            acc = in_vld && ((wt - rt) < 2);
            exp_we = acc ? ((wt % 2 == 0) ? 2'b01 : 2'b10) : 2'b00;
            n_tests++;
            if ({we_B, we_A} !== exp_we) begin
                n_fail++; $display("FAIL we got %b required %b", {we_B, we_A}, exp_we);
            end
            if (acc) begin
                for (int l = 0; l < NR; l++) begin
                    a = (wt % 2 == 0) ? write_addr_A[l*32 +: 32] : write_addr_B[l*32 +: 32];
                    n_tests++;
                    if (a !== 32'(wr_total % D)) begin
                        n_fail++; $display("FAIL wr_addr lane %0d got %0d required %0d", l, a, wr_total % D);
                    end
                end
                n_tests++;
                if (((wt % 2 == 0) ? din_A : din_B) !== in_dat) begin
                    n_fail++; $display("FAIL din got %h required %h", (wt % 2 == 0) ? din_A : din_B, in_dat);
                end
            end
            rd_ok = (rt < wt) && (occ + infl < 2);
            exp_re = rd_ok ? ((rt % 2 == 0) ? 2'b01 : 2'b10) : 2'b00;
            n_tests++;
            if ({re_B, re_A} !== exp_re) begin
                n_fail++; $display("FAIL re got %b required %b", {re_B, re_A}, exp_re);
            end
            if (rd_ok) begin
                for (int l = 0; l < NR; l++) begin
                    a = (rt % 2 == 0) ? read_addr_A[l*32 +: 32] : read_addr_B[l*32 +: 32];
                    n_tests++;
                    if (a !== 32'(rd_total % D)) begin
                        n_fail++; $display("FAIL rd_addr lane %0d got %0d required %0d", l, a, rd_total % D);
                    end
                end
            end
            n_tests++;
            if (out_vld !== (occ > 0)) begin
                n_fail++; $display("FAIL out_vld got %b required %b", out_vld, occ > 0);
            end
            pop = (occ > 0) && out_rdy;
            if (pop) begin
                n_tests++;
                if (sb.size() == 0) begin
                    n_fail++; $display("FAIL out_dat got %h required nothing (scoreboard empty)", out_dat);
                end else if (out_dat !== sb[0]) begin
                    n_fail++; $display("FAIL out_dat got %h required %h", out_dat, sb[0]);
                end
                if (sb.size() > 0) void'(sb.pop_front());
            end
            n_tests++;
            if ({wr_done, rd_done} !== {exp_wr_done, exp_rd_done}) begin
                n_fail++; $display("FAIL done got %b required %b", {wr_done, rd_done}, {exp_wr_done, exp_rd_done});
            end
            if (wr_done === 1'b1) wr_done_seen++;
            if (rd_done === 1'b1) rd_done_seen++;
            if ((re_A || re_B) && first_re < 0) first_re = cyc;
            if (out_vld && first_ov < 0) first_ov = cyc;
            ret = dout_vld_A || dout_vld_B;
            exp_wr_done = acc && (wr_total % D == D - 1);
            exp_rd_done = rd_ok && (rd_total % D == D - 1);
            if (acc) begin
                sb.push_back(in_dat);
                wr_total++;
            end
            if (rd_ok) rd_total++;
            occ  = occ + (ret ? 1 : 0) - (pop ? 1 : 0);
            infl = infl + (rd_ok ? 1 : 0) - (ret ? 1 : 0);
        end
    end

    task automatic drive(input bit v, input bit r);
        @(negedge clk);
        in_vld  = v;
        out_rdy = r;
        in_dat  = {$urandom, $urandom};
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1; in_vld = 1'b0; out_rdy = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        first_re = -1; first_ov = -1; wr_done_seen = 0; rd_done_seen = 0;
    endtask

    // Complete any partial tile, then drain the consumer side within a cycle budget.
    task automatic settle(output bit ok);
        int b = 0;
        #3;
        while ((wr_total % D != 0) && b < 40) begin drive(1'b1, 1'b1); #3; b++; end
        while ((sb.size() != 0 || occ != 0) && b < 200) begin drive(1'b0, 1'b1); #3; b++; end
        ok = (wr_total % D == 0) && (sb.size() == 0);
    endtask

    task automatic test_reset();
        do_reset();
        @(negedge clk); #3;
        n_tests++;
        if ({in_rdy, out_vld, bank_full, we_A, we_B, re_A, re_B} !== 8'b10000000) begin
            n_fail++; $display("FAIL reset_state got %b required 10000000", {in_rdy, out_vld, bank_full, we_A, we_B, re_A, re_B});
        end
    endtask

    task automatic test_single_tile();
        bit ok;
        do_reset();
        repeat (D) drive(1'b1, 1'b1);
        settle(ok);
        n_tests++;
        if (!ok) begin n_fail++; $display("FAIL single_drain got leftover %0d required 0", sb.size()); end
        n_tests++;
        if (wr_done_seen != 1 || rd_done_seen != 1) begin
            n_fail++; $display("FAIL single_done got wr %0d rd %0d required 1 1", wr_done_seen, rd_done_seen);
        end
        n_tests++;
        if (first_ov - first_re != 2) begin
            n_fail++; $display("FAIL single_latency got %0d required 2", first_ov - first_re);
        end
    endtask

    task automatic test_fill_stall();
        bit ok;
        int b = 0;
        do_reset();
        while (wr_total < 2 * D && b < 30) begin drive(1'b1, 1'b0); #3; b++; end
        repeat (5) drive(1'b1, 1'b0);
        #3;
        n_tests++;
        if ({bank_full, in_rdy, re_A, re_B, out_vld} !== 6'b110001) begin
            n_fail++; $display("FAIL fill_stall got %b required 110001", {bank_full, in_rdy, re_A, re_B, out_vld});
        end
        settle(ok);
        n_tests++;
        if (!ok || bank_full !== 2'b00) begin
            n_fail++; $display("FAIL fill_drain got leftover %0d full %b required 0 00", sb.size(), bank_full);
        end
    endtask

    task automatic test_stream();
        bit ok;
        int b = 0;
        do_reset();
        while (wr_total < 3 * D && b < 80) begin drive(1'b1, 1'b1); #3; b++; end
        settle(ok);
        n_tests++;
        if (!ok || wr_done_seen != 3 || rd_done_seen != 3) begin
            n_fail++; $display("FAIL stream got ok %0d wr %0d rd %0d required 1 3 3", ok, wr_done_seen, rd_done_seen);
        end
    endtask

    task automatic test_toggle();
        bit ok;
        bit t = 1'b0;
        do_reset();
        repeat (60) begin
            t = ~t;
            drive($urandom_range(0, 3) != 0, t);
        end
        settle(ok);
        n_tests++;
        if (!ok) begin n_fail++; $display("FAIL toggle_drain got leftover %0d required 0", sb.size()); end
    endtask

    task automatic test_reset_mid_read();
        bit seen = 1'b0;
        int b = 0;
        do_reset();
        while (wr_total < D && b < 20) begin drive(1'b1, 1'b0); #3; b++; end
        b = 0;
        while (!seen && b < 10) begin drive(1'b0, 1'b0); #3; seen = re_A || re_B; b++; end
        n_tests++;
        if (!seen) begin n_fail++; $display("FAIL midrst_re got 0 required 1"); end
        @(negedge clk);
        rst = 1'b1; in_vld = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        repeat (4) begin
            drive(1'b0, 1'b0);
            #3;
            n_tests++;
            if ({out_vld, bank_full, in_rdy} !== 4'b0001) begin
                n_fail++; $display("FAIL midrst_after got %b required 0001", {out_vld, bank_full, in_rdy});
            end
        end
    endtask

    task automatic test_random();
        bit ok;
        do_reset();
        repeat (300) drive($urandom_range(0, 9) < 6, $urandom_range(0, 1) == 1);
        settle(ok);
        n_tests++;
        if (!ok || wr_done_seen != rd_done_seen) begin
            n_fail++; $display("FAIL random got ok %0d wr %0d rd %0d required 1 and equal", ok, wr_done_seen, rd_done_seen);
        end
    endtask

    initial begin
        test_reset();
        test_single_tile();
        test_fill_stall();
        test_stream();
        test_toggle();
        test_reset_mid_read();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
